// File: rtl/cdc_4phase_pkg.sv
// Types shared by the halves of the 4-phase CDC link.
package cdc_4phase_pkg;

  typedef enum logic [1:0] {
    IDLE              = 2'd0,
    WAIT_ACK_ASSERT   = 2'd1,
    WAIT_ACK_DEASSERT = 2'd2
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdc_4phase_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer.
// The pointer moves past the granted channel on each update strobe.
module cdc_4phase_rr_arb
  import cdc_4phase_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  localparam int unsigned IdxWidth   = idx_width(NumChannels)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumChannels-1:0] req_i,
  input  logic                   en_i,
  input  logic                   update_i,
  output logic [IdxWidth-1:0]    gnt_idx_o,
  output logic                   gnt_valid_o
);

  logic [IdxWidth-1:0] ptr_q;
  logic [IdxWidth-1:0] cand;

  always_comb begin
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      cand = IdxWidth'((32'(ptr_q) + i) % NumChannels);
      if (en_i && !gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (update_i) begin
      ptr_q <= (32'(gnt_idx_o) == NumChannels - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/cdc_4phase_mux_src.sv
// Multi-channel source half of a 4-phase req/ack link: round-robin muxes
// valid/ready channels onto one registered req/data/tag link.
//
//   state             | meaning
//   IDLE              | no item in flight; arbitrate when ack is low
//   WAIT_ACK_ASSERT   | req high, waiting for synced ack to rise
//   WAIT_ACK_DEASSERT | req low, waiting for synced ack to fall
module cdc_4phase_mux_src
  import cdc_4phase_pkg::*;
#(
  parameter int unsigned NumChannels   = 4,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned SyncStages    = 2,
  parameter bit          Decoupled     = 1'b1,
  parameter int unsigned TimeoutCycles = 0,
  localparam int unsigned IdxWidth     = idx_width(NumChannels)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumChannels-1:0]                src_valid_i,
  output logic [NumChannels-1:0]                src_ready_o,
  input  logic [NumChannels-1:0][DataWidth-1:0] src_data_i,
  output logic                                  async_req_o,
  input  logic                                  async_ack_i,
  output logic [DataWidth-1:0]                  async_data_o,
  output logic [IdxWidth-1:0]                   async_chan_o,
  output logic                                  busy_o,
  output logic                                  timeout_o
);

  state_e                state_q, state_d;
  logic [SyncStages-1:0] ack_sync_q;
  logic [SyncStages-1:0] prime_q;
  logic                  ack_synced;
  logic                  primed;
  logic                  arb_en, arb_update, gnt_valid;
  logic [IdxWidth-1:0]   gnt_idx;
  logic                  req_q, req_d, load;
  logic [DataWidth-1:0]  data_q;
  logic [IdxWidth-1:0]   chan_q;
  logic [31:0]           to_cnt_q;
  logic                  timeout_q;

  assign ack_synced = ack_sync_q[SyncStages-1];
  assign primed     = prime_q[SyncStages-1];

  // The synchronizer restarts from 0 on reset, so grants wait until it has
  // refilled with real samples; otherwise a stale high ack would look low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_sync_q <= '0;
      prime_q    <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SyncStages-2:0], async_ack_i};
      prime_q    <= {prime_q[SyncStages-2:0], 1'b1};
    end
  end

  cdc_4phase_rr_arb #(
    .NumChannels (NumChannels)
  ) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (src_valid_i),
    .en_i        (arb_en),
    .update_i    (arb_update),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    arb_en      = 1'b0;
    arb_update  = 1'b0;
    load        = 1'b0;
    src_ready_o = '0;
    case (state_q)
      IDLE: begin
        arb_en = primed && !ack_synced;
        if (gnt_valid) begin
          load       = 1'b1;
          arb_update = 1'b1;
          req_d      = 1'b1;
          state_d    = WAIT_ACK_ASSERT;
          if (Decoupled) src_ready_o[gnt_idx] = 1'b1;
        end
      end
      WAIT_ACK_ASSERT: begin
        if (ack_synced) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK_DEASSERT;
        end
      end
      WAIT_ACK_DEASSERT: begin
        if (!ack_synced) begin
          state_d = IDLE;
          if (!Decoupled) src_ready_o[chan_q] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (load) begin
        data_q <= src_data_i[gnt_idx];
        chan_q <= gnt_idx;
      end
    end
  end

  // Counter saturates at the limit; the flag holds until IDLE is re-entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (state_q == IDLE) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (to_cnt_q != TimeoutCycles) to_cnt_q <= to_cnt_q + 32'd1;
      timeout_q <= (TimeoutCycles != 0) && (state_d != IDLE) &&
                   (timeout_q || (to_cnt_q + 32'd1 == TimeoutCycles));
    end
  end

  assign async_req_o  = req_q;
  assign async_data_o = data_q;
  assign async_chan_o = chan_q;
  assign busy_o       = (state_q != IDLE);
  assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_cdc_4phase_mux_src.sv
// Directed bench for cdc_4phase_mux_src: RR order, decoupled/coupled ready,
// timeout, reset with stale ack, and the single-channel build.
module tb_cdc_4phase_mux_src;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 4 channels, decoupled, timeout 10
  logic [3:0]       valid_a, ready_a;
  logic [3:0][31:0] data_a;
  logic             req_a, ack_a, busy_a, to_a;
  logic [31:0]      dout_a;
  logic [1:0]       chan_a;
  logic             auto_ack_a, man_ack_a;
  assign ack_a = auto_ack_a ? req_a : man_ack_a;

  // Instance B: 4 channels, coupled ready
  logic [3:0]       valid_b, ready_b;
  logic [3:0][31:0] data_b;
  logic             req_b, ack_b, busy_b, to_b;
  logic [31:0]      dout_b;
  logic [1:0]       chan_b;

  // Instance C: single channel
  logic [0:0]       valid_c, ready_c;
  logic [0:0][31:0] data_c;
  logic             req_c, ack_c, busy_c, to_c;
  logic [31:0]      dout_c;
  logic [0:0]       chan_c;

  cdc_4phase_mux_src #(.NumChannels(4), .DataWidth(32), .SyncStages(2),
                       .Decoupled(1'b1), .TimeoutCycles(10)) u_dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .src_valid_i(valid_a), .src_ready_o(ready_a),
    .src_data_i(data_a), .async_req_o(req_a), .async_ack_i(ack_a),
    .async_data_o(dout_a), .async_chan_o(chan_a), .busy_o(busy_a), .timeout_o(to_a));

  cdc_4phase_mux_src #(.NumChannels(4), .DataWidth(32), .SyncStages(2),
                       .Decoupled(1'b0), .TimeoutCycles(0)) u_dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .src_valid_i(valid_b), .src_ready_o(ready_b),
    .src_data_i(data_b), .async_req_o(req_b), .async_ack_i(ack_b),
    .async_data_o(dout_b), .async_chan_o(chan_b), .busy_o(busy_b), .timeout_o(to_b));

  cdc_4phase_mux_src #(.NumChannels(1), .DataWidth(32), .SyncStages(2),
                       .Decoupled(1'b1), .TimeoutCycles(0)) u_dut_c (
    .clk_i(clk_i), .rst_i(rst_i), .src_valid_i(valid_c), .src_ready_o(ready_c),
    .src_data_i(data_c), .async_req_o(req_c), .async_ack_i(ack_c),
    .async_data_o(dout_c), .async_chan_o(chan_c), .busy_o(busy_c), .timeout_o(to_c));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk_i);
    #2;
  endtask

  task automatic wait_issue_a(output logic [3:0] acc, output int pulses);
    logic prev, found;
    prev = req_a; acc = '0; pulses = 0; found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      if (ready_a != 4'b0) begin
        acc    |= ready_a;
        pulses += $countones(ready_a);
      end
      cyc();
      found = req_a && !prev;
      prev  = req_a;
    end
    check("t1_issue", 32'(found), 1);
  endtask

  logic [31:0] dat_tab [4];
  int          exp_tag [5];
  logic [31:0] c_tab   [2];

  initial begin
    logic [3:0] acc;
    int         pulses;
    logic       blocked;
    dat_tab = '{32'hC0DE_0000, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    exp_tag = '{0, 1, 2, 3, 0};
    c_tab   = '{32'hA5A5_0001, 32'h5A5A_0002};
    valid_a = '0; valid_b = '0; valid_c = '0;
    for (int i = 0; i < 4; i++) begin
      data_a[i] = dat_tab[i];
      data_b[i] = '0;
    end
    data_c = '0;
    auto_ack_a = 1'b0; man_ack_a = 1'b0; ack_b = 1'b0; ack_c = 1'b0;

    rst_i = 1'b1;
    cyc(3);
    check("rst_req",   32'(req_a),   0);
    check("rst_data",  dout_a,       0);
    check("rst_chan",  32'(chan_a),  0);
    check("rst_ready", 32'(ready_a), 0);
    check("rst_busy",  32'(busy_a),  0);
    check("rst_to",    32'(to_a),    0);
    rst_i = 1'b0;

    // Round-robin with all channels valid and an ideal receiver
    valid_a = 4'hF; auto_ack_a = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_issue_a(acc, pulses);
      check("t1_chan",   32'(chan_a), 32'(exp_tag[k]));
      check("t1_data",   dout_a, dat_tab[exp_tag[k]]);
      check("t1_ready",  32'(acc), 32'(1) << exp_tag[k]);
      check("t1_pulses", 32'(pulses), 1);
    end
    valid_a = '0;
    cyc(6);
    check("t1_idle", 32'(busy_a), 0);
    auto_ack_a = 1'b0; man_ack_a = 1'b0;
    cyc(2);

    // Only channel 2 valid
    data_a[2] = 32'hBEEF_0002; valid_a = 4'b0100; #1;
    check("t2_ready_grant", 32'(ready_a), 32'h4);
    cyc();
    check("t2_req",  32'(req_a),  1);
    check("t2_chan", 32'(chan_a), 2);
    check("t2_data", dout_a, 32'hBEEF_0002);
    valid_a = '0; man_ack_a = 1'b1; #1;
    check("t2_ready_after", 32'(ready_a), 0);
    cyc(2);
    check("t2_req_held", 32'(req_a), 1);
    cyc();
    check("t2_req_fall", 32'(req_a), 0);
    check("t2_busy",     32'(busy_a), 1);

    // Reset in WAIT_ACK_DEASSERT with ack still high
    data_a[2] = dat_tab[2]; valid_a = 4'hF;
    rst_i = 1'b1; cyc(); rst_i = 1'b0;
    check("t5_req_rst",  32'(req_a),  0);
    check("t5_busy_rst", 32'(busy_a), 0);
    blocked = 1'b0;
    for (int i = 0; i < 6; i++) begin
      blocked |= (|ready_a) | req_a;
      cyc();
    end
    check("t5_no_grant", 32'(blocked), 0);
    man_ack_a = 1'b0;
    cyc(2);
    check("t5_req_wait", 32'(req_a), 0);
    cyc();
    check("t5_req_resume", 32'(req_a), 1);
    check("t5_chan",       32'(chan_a), 0);
    check("t5_data",       dout_a, dat_tab[0]);

    // Timeout with ack withheld
    valid_a = '0;
    check("t4_to_start", 32'(to_a), 0);
    cyc(9);
    check("t4_to_early", 32'(to_a), 0);
    cyc();
    check("t4_to_rise", 32'(to_a), 1);
    cyc(3);
    check("t4_to_hold", 32'(to_a), 1);
    check("t4_req_hold", 32'(req_a), 1);
    man_ack_a = 1'b1;
    cyc(3);
    check("t4_req_fall", 32'(req_a), 0);
    check("t4_to_kept",  32'(to_a),  1);
    man_ack_a = 1'b0;
    cyc(3);
    check("t4_busy_end", 32'(busy_a), 0);
    check("t4_to_clear", 32'(to_a),   0);

    // Coupled ready, single item on channel 1
    data_b[1] = 32'h1234_5678; valid_b = 4'b0010; #1;
    check("t3_ready_pre", 32'(ready_b), 0);
    cyc();
    check("t3_req",  32'(req_b),  1);
    check("t3_chan", 32'(chan_b), 1);
    check("t3_data", dout_b, 32'h1234_5678);
    ack_b = 1'b1; blocked = 1'b0;
    for (int i = 0; i < 3; i++) begin
      blocked |= |ready_b;
      cyc();
    end
    check("t3_ready_hold", 32'(blocked), 0);
    check("t3_req_fall",   32'(req_b),   0);
    ack_b = 1'b0;
    cyc();
    check("t3_ready_early", 32'(ready_b), 0);
    cyc();
    check("t3_ready_pulse", 32'(ready_b), 32'h2);
    check("t3_busy_pulse",  32'(busy_b),  1);
    valid_b = '0;
    cyc();
    check("t3_busy_fall",  32'(busy_b),  0);
    check("t3_ready_done", 32'(ready_b), 0);

    // Single-channel build
    for (int j = 0; j < 2; j++) begin
      data_c[0] = c_tab[j]; valid_c = 1'b1; #1;
      check("t6_ready", 32'(ready_c), 1);
      cyc();
      check("t6_req",  32'(req_c),  1);
      check("t6_chan", 32'(chan_c), 0);
      check("t6_data", dout_c, c_tab[j]);
      valid_c = 1'b0; ack_c = 1'b1;
      cyc(3);
      check("t6_req_fall", 32'(req_c), 0);
      check("t6_data_hold", dout_c, c_tab[j]);
      ack_c = 1'b0;
      cyc(3);
      check("t6_idle", 32'(busy_c), 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
